// File: rtl/avalon_ram_slave.sv
// Avalon-MM word-organised RAM slave with programmable wait states, byte-lane
// writes, sticky error flag and a side preload port that bypasses the bus FSM.
module avalon_ram_slave #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t            state;
    logic [3:0]        counter;
    logic [31:0]       mem [2**ADDR_W];

    logic              req;
    logic              bad;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] inst_index;
    logic              load_rd;
    logic [31:0]       ack_data;
    logic              unused_inst_lsb;

    assign req         = read | write;
    assign index       = address[ADDR_W+1:2];
    assign inst_index  = inst_addr[ADDR_W+1:2];
    assign bad         = (address[1:0] != 2'b00) || (address[31:ADDR_W+2] != '0) || (read && write);
    assign waitrequest = req && (state != ACK);

    // readdata is captured on the edge entering ACK: zero for bad accesses,
    // the addressed word for good reads, untouched for good writes.
    assign load_rd  = bad || read;
    assign ack_data = bad ? 32'd0 : mem[index];

    assign unused_inst_lsb = ^inst_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= 4'd0;
            readdata  <= 32'd0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!inst_input && req) begin
                        counter <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state <= ACK;
                            if (load_rd) readdata <= ack_data;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter - 4'd1;
                        if (counter == 4'd1) begin
                            state <= ACK;
                            if (load_rd) readdata <= ack_data;
                        end
                    end
                end
                ACK: begin
                    if (req && bad) bus_error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory has no reset so preloaded programs survive a CPU reset; a reset
    // landing on the ACK edge suppresses the pending write.
    always_ff @(posedge clk) begin
        if (inst_input) begin
            mem[inst_index] <= instruction;
        end else if (reset && state == ACK && write && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) mem[index][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/avalon_ram_slave.md
Name: avalon_ram_slave

Overview:
- Avalon memory-mapped slave RAM; the responder end of the bus driven by top_level_cpu (address/read/write/writedata/byteenable out, readdata/waitrequest in).
- Word-organised synchronous memory with configurable wait states, byte-lane writes and error flagging.
- Separate preload port lets a testbench write program words before or between CPU runs.
- Sits beside the CPU in every CPU testbench.

Parameters:
ADDR_W, 6, word-index width; memory depth 2**ADDR_W words (default 64 words = 256 bytes).
WAIT_CYCLES, 1, extra BUSY cycles per transfer (0..15).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
address  input  32  byte address from master.
read  input  1  read request.
write  input  1  write request.
writedata  input  32  write data.
byteenable  input  4  lane enables; bit0 = bits 7:0 … bit3 = bits 31:24.
waitrequest  output  1  high = transfer not complete; master must hold its request signals.
readdata  output  32  read data; valid in the ACK cycle.
bus_error  output  1  sticky error flag.
inst_input  input  1  preload write enable.
inst_addr  input  8  preload byte address; word index = inst_addr[ADDR_W+1:2].
instruction  input  32  preload data, written as a full word.

Behaviour:
- Reset (reset=0 at clk edge):
  - FSM goes to IDLE; readdata=0; bus_error=0; counter=0.
  - Memory contents are retained, so preloads survive CPU reset.
  - Reset mid-transfer aborts the transfer; no write is committed.
- waitrequest = (read|write) && state!=ACK, combinational.
  - With no request, waitrequest=0.
- Decode:
  - Word index = address[ADDR_W+1:2].
  - Bad access: address[1:0]!=0, or address[31:ADDR_W+2]!=0, or read&&write both high.
- States:
  - IDLE:
    - If inst_input=1, stay in IDLE; pending requests stall with waitrequest high.
    - Else, if read|write: counter<=WAIT_CYCLES; go to ACK if WAIT_CYCLES==0, else BUSY.
  - BUSY:
    - If read|write is dropped: abort to IDLE; no memory effect, no error.
    - Else decrement counter; move to ACK when counter==1.
  - ACK (waitrequest=0, one cycle):
    - Read: readdata was loaded with mem[index] on the edge entering ACK.
    - Write: commit byte lanes with byteenable=1 at the edge leaving ACK; lanes with 0 keep old data.
    - Bad access: readdata=0, no write, bus_error<=1.
    - Always return to IDLE.
- Timing:
  - waitrequest is high for WAIT_CYCLES+1 cycles (IDLE cycle plus BUSY cycles), then low for 1 ACK cycle.
  - Back-to-back transfers: the next transfer starts in IDLE on the cycle after ACK.
- Request signals are sampled on entry to ACK (read data) and during ACK (write data and lanes).
  - Changes while waitrequest=1 violate protocol; behaviour is then defined only by the ACK-cycle values.
- readdata holds its last value outside ACK; it is only meaningful in ACK.
- Preload:
  - When inst_input=1, mem[inst_addr word] <= instruction each clk edge, regardless of reset.
  - Preload has priority; no bus write commits while inst_input=1, because the FSM is held in IDLE.
- bus_error clears only on reset.

Test Plan:
- Preload 0x24020010 at inst_addr 0x04; WAIT_CYCLES=1; read address 0x04 -> waitrequest high 2 cycles, then low 1 cycle with readdata=0x24020010; bus_error=0.
- Preload 0x11223344 at 0x10; write 0xAABBCCDD to 0x10 with byteenable=4'b0101; read 0x10 -> readdata=0x11BB33DD.
- WAIT_CYCLES=3; assert read at 0x08, drop it after 2 cycles; then write 0x00000008 to 0x1C -> first access aborts with no effect; the write completes after 4 high cycles; reading 0x1C returns 0x00000008.
- read and write both high at 0x0C, or read of unaligned 0x06 -> completes with an ACK cycle, readdata=0, bus_error=1 and stays 1; memory at 0x0C unchanged.
- Read of 0x00000100 (out of range, ADDR_W=6) -> readdata=0, bus_error=1. Then pulse reset=0 for 1 cycle -> bus_error=0, readdata=0; preloaded words are still readable.
- Hold inst_input=1 while read of 0x04 is pending -> waitrequest stays high for the whole preload. After inst_input=0, completes in WAIT_CYCLES+1 high cycles plus ACK, returning the newly preloaded value.
